// File: rtl/core_job_scheduler.sv
// Round-robin job dispatcher for NUM_CORES cores with busy tracking, completion count and drain handshake.
// Optional per-core busy watchdog is compiled in with `define CORE_WATCHDOG_EN.
module core_job_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int JOB_W      = 8,
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    input  logic [JOB_W-1:0]     job_id,
    output logic                 job_ready,
    output logic [NUM_CORES-1:0] core_start,
    output logic [JOB_W-1:0]     core_job_id,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 drain_req,
    output logic                 drained,
    output logic [NUM_CORES-1:0] busy_mask,
    output logic                 all_idle,
    output logic [CNT_W-1:0]     jobs_done,
    output logic [NUM_CORES-1:0] timeout_err
);

    localparam int PTR_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     rr_ptr, ptr_next;
    logic [NUM_CORES-1:0] busy, busy_next, grant, done_hits, tmo;
    logic [CNT_W-1:0]     done_cnt;
    logic                 take;

    assign job_ready = (state == ST_RUN) && (busy != '1) && !reset;
    assign take      = job_valid && job_ready;
    assign busy_mask = busy;
    assign all_idle  = (busy == '0);
    assign drained   = (state == ST_DRAINED);

    // First idle core at or above rr_ptr, wrapping; uses the pre-edge busy mask.
    always_comb begin
        int unsigned idx;
        grant    = '0;
        ptr_next = rr_ptr;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (take && (grant == '0) && !busy[idx]) begin
                grant[idx] = 1'b1;
                ptr_next   = (idx + 1 == NUM_CORES) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_comb begin
        done_hits = core_done & busy;
        done_cnt  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + CNT_W'(done_hits[i]);
        end
        busy_next = (busy & ~done_hits & ~tmo) | grant;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (drain_req) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)           state_next = ST_RUN;
                else if (busy_next == '0) state_next = ST_DRAINED;
            end
            ST_DRAINED: if (!drain_req) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            rr_ptr      <= '0;
            busy        <= '0;
            core_start  <= '0;
            core_job_id <= '0;
            jobs_done   <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= ptr_next;
            busy       <= busy_next;
            core_start <= grant;
            if (take) core_job_id <= job_id;
            jobs_done  <= jobs_done + done_cnt;
        end
    end

`ifdef CORE_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0]    wdog_cnt [NUM_CORES];
    logic [NUM_CORES-1:0] tmo_err;

    // A done on the limit cycle takes priority over the timeout.
    always_comb begin
        tmo = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            tmo[k] = busy[k] && !core_done[k] && (wdog_cnt[k] == WDOG_W'(WDOG_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_CORES; k++) wdog_cnt[k] <= '0;
            tmo_err <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
                if (grant[k])     wdog_cnt[k] <= '0;
                else if (busy[k]) wdog_cnt[k] <= wdog_cnt[k] + 1'b1;
            end
            tmo_err <= tmo_err | tmo;
        end
    end

    assign timeout_err = tmo_err;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_LIMIT == 0);
    assign tmo         = '0;
    assign timeout_err = '0;
`endif

endmodule
